// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the sequenced ALU
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_INC = 4'd5,
    OP_DEC = 4'd6,
    OP_NOT = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_MUL = 4'd10
  } op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd11;

  function automatic logic is_legal(input op_t op);
    return op < OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result bundle between controller and ALU
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  op_t              OP;
  logic             START;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] S_HI;
  logic             FC;
  logic             FZ;
  logic             FN;
  logic             FV;

  modport master (
    output A, B, OP, START,
    input  BUSY, DONE, S, S_HI, FC, FZ, FN, FV
  );

  modport slave (
    input  A, B, OP, START,
    output BUSY, DONE, S, S_HI, FC, FZ, FN, FV
  );

endinterface

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - iterative shift-and-add unsigned multiplier datapath
module mul_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;

  // product reflects the add of the current step, so the final value is
  // available combinationally during the last step
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign last     = (count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with START/BUSY/DONE sequencing and flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     CLK,
  input  logic     CLR_n,
  alu_seq_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  state_t             state_q;
  state_t             state_d;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;
  logic               alu_commit;
  logic               mul_commit;

  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   s_hi_q;
  flags_t             flags_q;
  logic               done_q;

  logic               sub_mode;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     arith;
  logic               arith_ovf;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  flags_t             alu_flags;
  flags_t             mul_flags;

  // ADD/SUB/INC/DEC share one WIDTH+1 adder; the extra bit is carry or borrow
  always_comb begin
    sub_mode = 1'b0;
    addend   = bus.B;
    case (bus.OP)
      OP_SUB: sub_mode = 1'b1;
      OP_INC: addend = WIDTH'(1);
      OP_DEC: begin
        sub_mode = 1'b1;
        addend   = WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign arith = sub_mode ? ({1'b0, bus.A} - {1'b0, addend})
                          : ({1'b0, bus.A} + {1'b0, addend});

  assign arith_ovf = sub_mode
      ? ((bus.A[MSB] != addend[MSB]) && (arith[MSB] != bus.A[MSB]))
      : ((bus.A[MSB] == addend[MSB]) && (arith[MSB] != bus.A[MSB]));

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (bus.OP)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        res   = arith[WIDTH-1:0];
        res_c = arith[WIDTH];
        res_v = arith_ovf;
      end
      OP_AND: res = bus.A & bus.B;
      OP_OR:  res = bus.A | bus.B;
      OP_XOR: res = bus.A ^ bus.B;
      OP_NOT: res = ~bus.A;
      OP_SHL: begin
        res   = {bus.A[MSB-1:0], 1'b0};
        res_c = bus.A[MSB];
      end
      OP_SHR: begin
        res   = {1'b0, bus.A[MSB:1]};
        res_c = bus.A[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_flags.c = res_c;
    alu_flags.z = (res == '0);
    alu_flags.n = res[MSB];
    alu_flags.v = res_v;
  end

  always_comb begin
    mul_flags.c = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags.z = (mul_product == '0);
    mul_flags.n = mul_product[2*WIDTH-1];
    mul_flags.v = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    alu_commit = 1'b0;
    mul_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (bus.OP == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL_RUN;
          end else begin
            alu_commit = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        mul_step = 1'b1;
        if (mul_last) begin
          mul_commit = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // illegal codes still acknowledge with DONE but leave results untouched
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      s_hi_q  <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (alu_commit) begin
        done_q <= 1'b1;
        if (is_legal(bus.OP)) begin
          s_q     <= res;
          s_hi_q  <= '0;
          flags_q <= alu_flags;
        end
      end
      if (mul_commit) begin
        done_q  <= 1'b1;
        s_q     <= mul_product[WIDTH-1:0];
        s_hi_q  <= mul_product[2*WIDTH-1:WIDTH];
        flags_q <= mul_flags;
      end
    end
  end

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (CLK),
    .clr_n   (CLR_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.A),
    .b       (bus.B),
    .last    (mul_last),
    .product (mul_product)
  );

  assign bus.S    = s_q;
  assign bus.S_HI = s_hi_q;
  assign bus.FC   = flags_q.c;
  assign bus.FZ   = flags_q.z;
  assign bus.FN   = flags_q.n;
  assign bus.FV   = flags_q.v;
  assign bus.DONE = done_q;
  assign bus.BUSY = (state_q == MUL_RUN);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed bench for alu_seq at WIDTH 8 and 16
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic        legal;
    logic [63:0] s;
    logic [63:0] hi;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } res_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [63:0] s;
    logic [63:0] hi;
    logic [3:0]  f;
  } obs_t;

  logic CLK;
  logic CLR_n;
  int   checks;
  int   failures;
  res_t exp8;
  res_t exp16;
  obs_t last_obs;

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut8  (.CLK(CLK), .CLR_n(CLR_n), .bus(bus8));
  alu_seq #(.WIDTH(16)) dut16 (.CLK(CLK), .CLR_n(CLR_n), .bus(bus16));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // reference: plain integer arithmetic on unsigned/signed interpretations
  function automatic res_t model(input int w, input op_t op, input longint a_in, input longint b_in);
    longint m, half, a, b, sa, sb, sv, full, p;
    res_t r;
    r = '0;
    r.legal = 1'b1;
    m = longint'(1) << w;
    half = m / 2;
    a = a_in % m;
    b = b_in % m;
    if (op == OP_INC || op == OP_DEC) b = 1;
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    case (op)
      OP_ADD, OP_INC: begin
        full = a + b;
        r.s = full % m;
        r.c = (full >= m);
        sv = sa + sb;
        r.v = (sv >= half) || (sv < -half);
      end
      OP_SUB, OP_DEC: begin
        full = a - b;
        r.s = (full + m) % m;
        r.c = (a < b);
        sv = sa - sb;
        r.v = (sv >= half) || (sv < -half);
      end
      OP_AND: r.s = a & b;
      OP_OR:  r.s = a | b;
      OP_XOR: r.s = a ^ b;
      OP_NOT: r.s = m - 1 - a;
      OP_SHL: begin
        r.s = (2 * a) % m;
        r.c = (a >= half);
      end
      OP_SHR: begin
        r.s = a / 2;
        r.c = ((a % 2) == 1);
      end
      OP_MUL: begin
        p = a * b;
        r.s = p % m;
        r.hi = p / m;
        r.c = (p / m) != 0;
        r.z = (p == 0);
        r.n = ((p / m) >= half);
      end
      default: r.legal = 1'b0;
    endcase
    if (op != OP_MUL) begin
      r.z = (r.s == 0);
      r.n = (r.s >= half);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int w, input logic start, input op_t op, input longint a, input longint b);
    if (w == 16) begin
      bus16.START = start; bus16.OP = op; bus16.A = 16'(a); bus16.B = 16'(b);
    end else begin
      bus8.START = start; bus8.OP = op; bus8.A = 8'(a); bus8.B = 8'(b);
    end
  endtask

  task automatic sample(input int w, output obs_t o);
    if (w == 16) begin
      o.busy = bus16.BUSY; o.done = bus16.DONE;
      o.s = 64'(bus16.S); o.hi = 64'(bus16.S_HI);
      o.f = {bus16.FC, bus16.FZ, bus16.FN, bus16.FV};
    end else begin
      o.busy = bus8.BUSY; o.done = bus8.DONE;
      o.s = 64'(bus8.S); o.hi = 64'(bus8.S_HI);
      o.f = {bus8.FC, bus8.FZ, bus8.FN, bus8.FV};
    end
  endtask

  task automatic check_idle(input int w);
    obs_t o;
    sample(w, o);
    check($sformatf("reset_s_w%0d", w), o.s, 64'd0);
    check($sformatf("reset_hi_w%0d", w), o.hi, 64'd0);
    check($sformatf("reset_flags_w%0d", w), 64'(o.f), 64'd0);
    check($sformatf("reset_busy_done_w%0d", w), 64'({o.busy, o.done}), 64'd0);
  endtask

  // issue one op, scramble inputs after the START edge, optionally poke START
  // again mid-MUL, then compare against the model when DONE arrives
  task automatic run(input int w, input op_t op, input longint a, input longint b, input bit poke);
    obs_t o;
    res_t e, cur;
    int n, busy_n;
    drive(w, 1'b1, op, a, b);
    n = 0;
    busy_n = 0;
    do begin
      tick;
      n++;
      if (n == 1) drive(w, 1'b0, op_t'(4'($urandom)), longint'($urandom), longint'($urandom));
      if (poke && n == 3) drive(w, 1'b1, OP_ADD, 1, 1);
      if (poke && n == 4) drive(w, 1'b0, OP_ADD, 0, 0);
      sample(w, o);
      if (o.busy) busy_n++;
    end while (!o.done && n < 4 * w);
    e = model(w, op, a, b);
    if (e.legal) begin
      if (w == 16) exp16 = e;
      else exp8 = e;
    end
    cur = (w == 16) ? exp16 : exp8;
    check($sformatf("done_w%0d_op%0d", w, op), 64'(o.done), 64'd1);
    check($sformatf("latency_w%0d_op%0d", w, op), 64'(n), 64'((op == OP_MUL) ? w + 1 : 1));
    check($sformatf("busy_cycles_w%0d_op%0d", w, op), 64'(busy_n), 64'((op == OP_MUL) ? w : 0));
    check($sformatf("s_w%0d_op%0d", w, op), o.s, cur.s);
    check($sformatf("s_hi_w%0d_op%0d", w, op), o.hi, cur.hi);
    check($sformatf("flags_w%0d_op%0d", w, op), 64'(o.f), 64'({cur.c, cur.z, cur.n, cur.v}));
    last_obs = o;
  endtask

  initial begin
    obs_t o;
    int dones;
    int w;
    checks = 0;
    failures = 0;
    exp8 = '0;
    exp16 = '0;
    CLR_n = 1'b0;
    drive(8, 1'b0, OP_ADD, 0, 0);
    drive(16, 1'b0, OP_ADD, 0, 0);
    tick;
    tick;
    CLR_n = 1'b1;
    check_idle(8);
    check_idle(16);

    run(8, OP_ADD, 'h7F, 'h01, 0);
    check("tp_add_7f_s", last_obs.s, 64'h80);
    check("tp_add_7f_flags_cznv", 64'(last_obs.f), 64'b0011);
    tick;
    sample(8, o);
    check("done_one_pulse", 64'(o.done), 64'd0);
    check("s_held", o.s, 64'h80);

    run(8, OP_ADD, 'hFF, 'h01, 0);
    check("tp_add_ff_flags_cznv", 64'(last_obs.f), 64'b1100);
    run(8, OP_SUB, 'h05, 'h07, 0);
    check("tp_sub_s", last_obs.s, 64'hFE);
    run(8, OP_DEC, 'h80, 'h33, 0);
    check("tp_dec_s", last_obs.s, 64'h7F);
    run(8, OP_MUL, 'hFF, 'hFF, 0);
    check("tp_mul_ff_hi", last_obs.hi, 64'hFE);
    run(8, OP_MUL, 'h0F, 'h11, 0);
    check("tp_mul_0f_s", last_obs.s, 64'hFF);
    tick;

    run(8, OP_MUL, 'hA5, 'h3C, 1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      sample(8, o);
      if (o.done) dones++;
    end
    check("poke_extra_done", 64'(dones), 64'd0);
    check("poke_s_held", o.s, exp8.s);

    drive(8, 1'b1, OP_MUL, 'h37, 'h59);
    tick;
    drive(8, 1'b0, OP_ADD, 0, 0);
    tick;
    tick;
    tick;
    CLR_n = 1'b0;
    tick;
    CLR_n = 1'b1;
    exp8 = '0;
    exp16 = '0;
    check_idle(8);
    check_idle(16);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      sample(8, o);
      if (o.done || o.busy) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run(8, OP_ADD, 'h02, 'h03, 0);
    check("tp_after_abort_s", last_obs.s, 64'h05);

    run(8, OP_ADD, 'h01, 'h01, 0);
    run(8, op_t'(4'hF), 'h55, 'hAA, 0);
    check("tp_illegal_s", last_obs.s, 64'h02);
    tick;

    run(16, OP_MUL, 'hFFFF, 'hFFFF, 0);
    check("tp_mul16_hi", last_obs.hi, 64'hFFFE);
    check("tp_mul16_s", last_obs.s, 64'h0001);

    for (int i = 0; i < 60; i++) begin
      w = (i % 3 == 0) ? 16 : 8;
      run(w, op_t'(4'($urandom_range(0, 15))), longint'($urandom), longint'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
